mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit of the Minisys-1A pipeline, between the EX/MEM register and the write-back mux. It turns one load or store request into a handshaked word access on the data RAM/IO bus:
- byte-enable generation and store-lane replication;
- load extraction with sign/zero extension;
- address-alignment exceptions and a bus timeout.

It returns `read_data` and a one-cycle `load_valid` to write-back, and holds `stall` high while an access is in flight.

## Interface
Parameters:
- TIMEOUT, 16, cycles of bus_req without bus_ready before a bus error.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- mem_req  in  1  request valid from EX/MEM.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal, treated as word.
- mem_unsigned  in  1  zero-extend loads (lbu/lhu).
- addr  in  32  byte address.
- store_data  in  32  rt value.
- flush  in  1  pipeline flush from CP0 exception logic.
- bus_req  out  1  access request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, addr[1:0] forced to 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word.
- bus_ready  in  1  access complete.
- read_data  out  32  extended load result (to write-back).
- load_valid  out  1  read_data valid, one-cycle pulse.
- stall  out  1  freeze IF..EX.
- exc  out  1  exception pulse.
- exc_code  out  5  4 = AdEL, 5 = AdES, 7 = DBE.
- bad_vaddr  out  32  faulting address.

## Operation
- States: IDLE, BUS, DONE.
- IDLE + mem_req + !flush:
  - Misaligned access (half with addr[0] = 1, or word with addr[1:0] != 0) → no bus access. Next cycle: exc = 1, exc_code = 4 for a load or 5 for a store, bad_vaddr = addr. Stay in IDLE.
  - Aligned access → register bus_addr, bus_we, bus_be, bus_wdata, latch size/unsigned/addr[1:0], go to BUS.
- bus_be:
  - byte: 1 << addr[1:0];
  - half: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1;
  - word: 4'b1111.
  - Loads drive the same enables.
- bus_wdata: byte → {4{sd[7:0]}}; half → {2{sd[15:0]}}; word → sd.
- BUS: bus_req = 1, and outputs hold stable until bus_ready is sampled high.
  - On bus_ready, a load latches the selected lane extended to 32 bits into read_data. Go to DONE.
- Timeout: a counter clears on entry to BUS. When it reaches TIMEOUT-1 with no ready:
  - drop bus_req;
  - exc = 1, exc_code = 7, bad_vaddr = address;
  - go to IDLE.
- DONE: load_valid = 1 for loads only (0 for stores). Return to IDLE. A new mem_req is not accepted in DONE.
- flush:
  - In IDLE it blocks acceptance.
  - In BUS the access completes (stores are not aborted once issued), but load_valid and exc for that access are suppressed. The suppression flag is sticky until IDLE.
- stall = (IDLE & mem_req & !flush & aligned) | (state == BUS).
- read_data holds its last value until the next load completes.

## Timing
- Reset (asynchronous, reset = 0):
  - state = IDLE; counter = 0.
  - bus_req, bus_we, bus_be, load_valid, exc, stall-state = 0.
  - bus_addr, bus_wdata, read_data, bad_vaddr = 0; exc_code = 0.
- Reset mid-access drops bus_req immediately, with no completion pulse.
- Zero-wait bus (bus_ready tied high):
  - accept at edge E0;
  - bus_req high in cycle E0..E1, with ready sampled at E1;
  - load_valid high in E1..E2;
  - stall high in the accept cycle and E0..E1, low from E1.
  - Minimum 2 cycles per access; back-to-back throughput is one access per 3 cycles.
- bus_ready while not in BUS is ignored.
- Error latency: alignment exc asserts one cycle after the accept edge; DBE asserts on the cycle after the timeout edge.

## Structure
- Shared package: mem_size encodings; exc_code constants (EXC_ADEL = 4, EXC_ADES = 5, EXC_DBE = 7); state encoding.
- Sub-module `load_align`: combinational lane select plus sign/zero extension from (rdata, size, unsigned, offset). It is reused by any future uncached IO path.

## Test plan
- lw at 0x100, bus_rdata = 0xDEADBEEF, ready on the first BUS cycle → bus_be = 4'b1111, bus_addr = 0x100, read_data = 0xDEADBEEF, load_valid for 1 cycle, stall lasts 2 cycles.
- lb at 0x103 with rdata = 0x80123456 → bus_be = 4'b1000, read_data = 0xFFFFFF80. lbu at the same address → 0x00000080. lh at 0x102 → 0xFFFF8012.
- sh at 0x206, sd = 0x0000ABCD → bus_we = 1, bus_be = 4'b1100, bus_wdata = 0xABCDABCD, no load_valid.
- lw at 0x101 → no bus_req, exc = 1, exc_code = 4, bad_vaddr = 0x101. sh at 0x3 → exc_code = 5.
- bus_ready never asserted, TIMEOUT = 16 → bus_req high exactly 16 cycles, then exc_code = 7, stall drops.
- flush during BUS of a lw with ready after 3 cycles → access completes, load_valid stays 0. Reset asserted mid-BUS → bus_req 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: size encodings,
// CP0 exception codes, FSM states and lane helpers.
package mem_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    // Size 3 is illegal and behaves exactly like a word access.
    function automatic logic is_aligned(logic [1:0] size, logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~off[0];
            default:   return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(logic [1:0] size, logic [31:0] sd);
        case (size)
            SIZE_BYTE: return {4{sd[7:0]}};
            SIZE_HALF: return {2{sd[15:0]}};
            default:   return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Word-wide data RAM/IO bus between the load/store unit (master) and memory (slave).
interface mem_lsu_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ready
    );

endinterface

// File: rtl/mem_lsu_load_align.sv
// Combinational load lane select with sign/zero extension; shared with the
// uncached IO path.
module mem_lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[7:0];
        unique case (offset_i)
            2'd0: byte_lane = rdata_i[7:0];
            2'd1: byte_lane = rdata_i[15:8];
            2'd2: byte_lane = rdata_i[23:16];
            2'd3: byte_lane = rdata_i[31:24];
        endcase
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SIZE_BYTE: data_o = is_unsigned_i ? {24'b0, byte_lane}
                                              : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: data_o = is_unsigned_i ? {16'b0, half_lane}
                                              : {{16{half_lane[15]}}, half_lane};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Minisys-1A memory-stage load/store unit: one handshaked word access per
// request, with alignment checks, bus timeout and flush suppression.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    mem_lsu_if.master   bus,
    output logic [31:0] read_data,
    output logic        load_valid,
    output logic        stall,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic [31:0] bad_vaddr
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_we_q, bus_we_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic            flushed_q, flushed_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            load_valid_q, load_valid_d;
    logic            exc_q, exc_d;
    logic [4:0]      exc_code_q, exc_code_d;
    logic [31:0]     bad_vaddr_q, bad_vaddr_d;

    logic            req_aligned;
    logic            suppress;
    logic [31:0]     load_data;

    mem_lsu_load_align u_load_align (
        .rdata_i       (bus.bus_rdata),
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .offset_i      (off_q),
        .data_o        (load_data)
    );

    assign req_aligned = is_aligned(mem_size, addr[1:0]);
    // A flush seen at any point of the access kills its write-back and exception.
    assign suppress    = flushed_q | flush;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        flushed_d    = flushed_q;
        read_data_d  = read_data_q;
        load_valid_d = 1'b0;
        exc_d        = 1'b0;
        exc_code_d   = exc_code_q;
        bad_vaddr_d  = bad_vaddr_q;

        unique case (state_q)
            StIdle: begin
                flushed_d = 1'b0;
                if (mem_req && !flush) begin
                    if (!req_aligned) begin
                        exc_d       = 1'b1;
                        exc_code_d  = mem_we ? EXC_ADES : EXC_ADEL;
                        bad_vaddr_d = addr;
                    end else begin
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_we_d    = mem_we;
                        bus_be_d    = byte_en(mem_size, addr[1:0]);
                        bus_wdata_d = lane_wdata(mem_size, store_data);
                        size_d      = mem_size;
                        uns_d       = mem_unsigned;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                        state_d     = StBus;
                    end
                end
            end
            StBus: begin
                if (flush) flushed_d = 1'b1;
                if (bus.bus_ready) begin
                    if (!bus_we_q && !suppress) begin
                        read_data_d  = load_data;
                        load_valid_d = 1'b1;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    if (!suppress) begin
                        exc_d       = 1'b1;
                        exc_code_d  = EXC_DBE;
                        bad_vaddr_d = {bus_addr_q[31:2], off_q};
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                flushed_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= 4'b0;
            bus_addr_q   <= 32'b0;
            bus_wdata_q  <= 32'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b0;
            flushed_q    <= 1'b0;
            read_data_q  <= 32'b0;
            load_valid_q <= 1'b0;
            exc_q        <= 1'b0;
            exc_code_q   <= 5'b0;
            bad_vaddr_q  <= 32'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            flushed_q    <= flushed_d;
            read_data_q  <= read_data_d;
            load_valid_q <= load_valid_d;
            exc_q        <= exc_d;
            exc_code_q   <= exc_code_d;
            bad_vaddr_q  <= bad_vaddr_d;
        end
    end

    assign bus.bus_req   = (state_q == StBus);
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign read_data  = read_data_q;
    assign load_valid = load_valid_q;
    assign exc        = exc_q;
    assign exc_code   = exc_code_q;
    assign bad_vaddr  = bad_vaddr_q;
    assign stall      = ((state_q == StIdle) && mem_req && !flush && req_aligned)
                      || (state_q == StBus);

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table plus hand sequences, with a
// scoreboard of expected load_valid / exc events.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_unsigned = 1'b0, flush = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] read_data, bad_vaddr;
    logic        load_valid, stall, exc;
    logic [4:0]  exc_code;

    mem_lsu_if bus_if ();

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .store_data   (store_data),
        .flush        (flush),
        .bus          (bus_if),
        .read_data    (read_data),
        .load_valid   (load_valid),
        .stall        (stall),
        .exc          (exc),
        .exc_code     (exc_code),
        .bad_vaddr    (bad_vaddr)
    );

    always #5 clock = ~clock;

    // kind: 0 = completes, 1 = misaligned, 2 = bus timeout
    typedef struct {
        int          kind;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [4:0]  code;
    } vec_t;

    typedef struct {
        bit          is_exc;
        logic [31:0] data;
        logic [4:0]  code;
    } sb_t;

    sb_t         sb_q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] last_rd = '0;
    vec_t        vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_exc, input logic [31:0] data, input logic [4:0] code);
        sb_t e;
        e.is_exc = is_exc;
        e.data   = data;
        e.code   = code;
        sb_q.push_back(e);
    endtask

    // Every load_valid or exc cycle must match the oldest expected event.
    always @(negedge clock) begin
        if (reset && (load_valid || exc)) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: load_valid=%b exc=%b, expected none",
                         load_valid, exc);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("event_kind", 32'({exc, load_valid}), e.is_exc ? 32'd2 : 32'd1);
                if (e.is_exc) begin
                    chk("exc_code", 32'(exc_code), 32'(e.code));
                    chk("bad_vaddr", bad_vaddr, e.data);
                end else begin
                    chk("read_data", read_data, e.data);
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        mem_req      = 1'b1;
        mem_we       = v.we;
        mem_size     = v.size;
        mem_unsigned = v.uns;
        addr         = v.addr;
        store_data   = v.sd;
        bus_if.bus_rdata = v.rdata;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc;
        bit done;
        @(posedge clock); #1;
        drive_req(v);
        @(negedge clock);
        chk({nm, "_stall_req"}, 32'(stall), (v.kind == 1) ? 32'd0 : 32'd1);
        @(posedge clock); #1;
        mem_req = 1'b0;
        if (v.kind == 1) push_ev(1'b1, v.addr, v.code);
        else if (v.kind == 2) push_ev(1'b1, v.addr, EXC_DBE);
        else if (!v.we) begin
            push_ev(1'b0, v.rd, 5'd0);
            last_rd = v.rd;
        end
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clock);
            if (!bus_if.bus_req) done = 1'b1;
            else begin
                if (cyc == 0) begin
                    chk({nm, "_bus_addr"}, bus_if.bus_addr, v.addr & 32'hFFFF_FFFC);
                    chk({nm, "_bus_we"}, 32'(bus_if.bus_we), 32'(v.we));
                    chk({nm, "_bus_be"}, 32'(bus_if.bus_be), 32'(v.be));
                    if (v.we) chk({nm, "_bus_wdata"}, bus_if.bus_wdata, v.wdata);
                end
                bus_if.bus_ready = (v.delay >= 0) && (cyc >= v.delay);
                cyc++;
            end
        end
        bus_if.bus_ready = 1'b0;
        chk({nm, "_bus_cycles"}, 32'(cyc),
            (v.kind == 1) ? 32'd0 : (v.kind == 2) ? 32'(TO) : 32'(v.delay + 1));
        chk({nm, "_stall_end"}, 32'(stall), 32'd0);
        chk({nm, "_rd_hold"}, read_data, last_rd);
        #1;
        chk({nm, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   cyc;
        vecs[0]  = '{0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'hF, 32'h0, 32'hDEADBEEF, 5'd0};
        vecs[1]  = '{0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 4'h8, 32'h0, 32'hFFFFFF80, 5'd0};
        vecs[2]  = '{0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 4'h8, 32'h0, 32'h00000080, 5'd0};
        vecs[3]  = '{0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80123456, 0, 4'hC, 32'h0, 32'hFFFF8012, 5'd0};
        vecs[4]  = '{0, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h80123456, 2, 4'h3, 32'h0, 32'h00003456, 5'd0};
        vecs[5]  = '{0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h80123456, 0, 4'h2, 32'h0, 32'h00000034, 5'd0};
        vecs[6]  = '{0, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h80123456, 1, 4'h4, 32'h0, 32'h00000012, 5'd0};
        vecs[7]  = '{0, 1'b1, 2'd1, 1'b0, 32'h206, 32'h0000ABCD, 32'h0, 0, 4'hC, 32'hABCDABCD, 32'h0, 5'd0};
        vecs[8]  = '{0, 1'b1, 2'd0, 1'b0, 32'h011, 32'h123456A5, 32'h0, 1, 4'h2, 32'hA5A5A5A5, 32'h0, 5'd0};
        vecs[9]  = '{0, 1'b1, 2'd2, 1'b0, 32'h020, 32'hCAFEF00D, 32'h0, 3, 4'hF, 32'hCAFEF00D, 32'h0, 5'd0};
        vecs[10] = '{0, 1'b0, 2'd3, 1'b0, 32'h040, 32'h0, 32'h11223344, 0, 4'hF, 32'h0, 32'h11223344, 5'd0};
        vecs[11] = '{1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 5'd4};
        vecs[12] = '{1, 1'b1, 2'd1, 1'b0, 32'h003, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 5'd5};
        vecs[13] = '{1, 1'b0, 2'd1, 1'b0, 32'h105, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 5'd4};
        vecs[14] = '{1, 1'b0, 2'd3, 1'b0, 32'h202, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 5'd4};
        vecs[15] = '{2, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, -1, 4'hF, 32'h0, 32'h0, 5'd7};

        bus_if.bus_rdata = '0;
        bus_if.bus_ready = 1'b0;

        repeat (2) @(negedge clock);
        chk("reset_bus_ctl", 32'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}), 32'd0);
        chk("reset_bus_addr", bus_if.bus_addr, 32'd0);
        chk("reset_bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("reset_outs", 32'({load_valid, exc, stall, exc_code}), 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_bad_vaddr", bad_vaddr, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // bus_ready outside BUS must not start or complete anything
        @(posedge clock); #1;
        bus_if.bus_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("idle_ready_req", 32'(bus_if.bus_req), 32'd0);
        end
        @(posedge clock); #1;
        bus_if.bus_ready = 1'b0;

        // flush in IDLE blocks acceptance
        drive_req(vecs[0]);
        flush = 1'b1;
        @(negedge clock);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        mem_req = 1'b0;
        flush = 1'b0;
        @(negedge clock);
        chk("idle_flush_req", 32'(bus_if.bus_req), 32'd0);

        // flush during BUS: access completes, no load_valid
        v = vecs[0];
        v.addr = 32'h104;
        v.rdata = 32'h00000055;
        @(posedge clock); #1;
        drive_req(v);
        @(posedge clock); #1;
        mem_req = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            if (!bus_if.bus_req) break;
            flush = (cyc == 0);
            bus_if.bus_ready = (cyc >= 3);
            cyc++;
        end
        flush = 1'b0;
        bus_if.bus_ready = 1'b0;
        chk("flush_bus_cycles", 32'(cyc), 32'd4);
        @(negedge clock);
        chk("flush_no_event", 32'(sb_q.size()), 32'd0);

        // reset mid-BUS drops everything immediately
        @(posedge clock); #1;
        drive_req(vecs[15]);
        @(posedge clock); #1;
        mem_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrst_req_before", 32'(bus_if.bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_bus_ctl", 32'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}), 32'd0);
        chk("midrst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("midrst_outs", 32'({load_valid, exc, stall, exc_code}), 32'd0);
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_bad_vaddr", bad_vaddr, 32'd0);
        last_rd = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        run_vec(vecs[3], "post_reset");

        repeat (2) @(negedge clock);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
